dpd_coef_ctrl: RTL and testbench
================================

# dpd_coef_ctrl

Coefficient and observation controller for the 3-tap, degree-5 DPD core. It double-buffers the 15 complex coefficients, so software or an adaptation engine can load a full set while the core keeps running on the old set. The new set reaches the core atomically on a frame boundary. On request it also snapshots the core's 15 complex basis terms (yy) and streams them out one at a time for the adaptation engine.

## Interface
- W, 20: coefficient / basis component width, signed
- N, 15: number of complex coefficients (3 memory taps x 5 orders)
- C0_RESET, 20'sh40000: reset value of coef_i[0]; all other coefficient components reset to 0
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- wr_valid  in  1  coefficient write request
- wr_ready  out  1  write accepted when wr_valid & wr_ready
- wr_idx  in  4  coefficient index 0..N-1
- wr_i / wr_q  in  W  coefficient real / imag
- wr_err  out  1  one-cycle pulse: accepted write had wr_idx >= N (data dropped)
- commit  in  1  pulse: request shadow->active swap
- frame_sync  in  1  pulse: safe swap point
- commit_busy  out  1  swap pending (ARMED)
- commit_done  out  1  one-cycle pulse, coincident with first cycle of new coef outputs
- coef_i / coef_q  out  N*W  active coefficients, entry k at [k*W +: W], to core
- yy_i / yy_q  in  N*W  basis terms from core, same packing
- cap_req  in  1  pulse: request basis snapshot
- cap_valid  out  1  stream data valid
- cap_ready  in  1  downstream ready
- cap_idx  out  4  index of current entry
- cap_i / cap_q  out  W  basis entry k
- cap_last  out  1  high with entry N-1

## Operation
- Two banks: ACTIVE drives coef_*, SHADOW takes writes. After reset, both banks hold C0_RESET at coef_i[0] and 0 everywhere else.
- Write path: wr_ready = 1 in IDLE and 0 in ARMED. An accepted write with wr_idx < N updates SHADOW[wr_idx] on that edge. An accepted write with wr_idx >= N is dropped and wr_err pulses on the next cycle.
- Commit FSM, states IDLE / ARMED:
  - IDLE + commit -> ARMED.
  - ARMED + frame_sync -> IDLE. ACTIVE <= SHADOW on that same edge, and commit_done pulses.
  - commit in ARMED is ignored. frame_sync in IDLE is ignored.
  - After a swap, both banks are equal, so partial updates to SHADOW are incremental.
- commit together with an accepted write in the same IDLE cycle: the write lands in SHADOW and is included in the pending swap.
- Capture FSM, states C_IDLE / C_STREAM:
  - C_IDLE + cap_req: register all N yy entries into the snapshot, idx <= 0, go to C_STREAM.
  - C_STREAM: cap_valid = 1. On cap_valid & cap_ready, idx increments. If idx == N-1, return to C_IDLE instead.
  - cap_req during C_STREAM is ignored; the snapshot is never modified mid-stream.
- The two FSMs are independent; a swap may occur during streaming.
- No arithmetic: all data is moved bit-exactly with no saturation or rounding.

## Timing
- All outputs are registered.
- Reset values: wr_ready = 1, wr_err = 0, commit_busy = 0, commit_done = 0, cap_valid = 0, cap_idx = 0, cap_i/cap_q = 0, cap_last = 0, coef_* = reset bank.
- commit sampled at edge t -> commit_busy = 1 from t+1.
- frame_sync sampled at edge s (while ARMED) -> from s+1: coef_* new, commit_done = 1 for that one cycle, commit_busy = 0, wr_ready = 1.
- cap_req sampled at edge t captures yy as present at t. From t+1: cap_valid = 1 with entry 0.
- The stream holds cap_idx/cap_i/cap_q/cap_last stable while cap_valid & !cap_ready.
- Minimum stream length is N cycles. cap_valid drops the cycle after the final handshake.
- A new cap_req is accepted no earlier than the first C_IDLE cycle.
- Reset asserted mid-operation: both banks return to reset values, a pending commit is cancelled, and the stream is aborted (cap_valid = 0 immediately and asynchronously).

## Test plan
- Reset: check coef_i[0] = 0x40000, all other coef components = 0, wr_ready = 1, cap_valid = 0.
- Write idx 3 = (0x00100, 0x3FF00), then commit, then frame_sync 10 cycles later:
  - coef_* unchanged until frame_sync.
  - entry 3 = (0x00100, 0x3FF00) the cycle after, with commit_done pulsing in that same cycle.
  - wr_ready = 0 throughout ARMED.
- Write with wr_idx = 15 -> wr_err pulses once; neither bank changes after a following commit and frame_sync.
- Repeat commit while ARMED, and frame_sync while IDLE -> exactly one swap and one commit_done.
- Drive yy entry k = (k, -k), pulse cap_req, and toggle cap_ready 1/0 every cycle:
  - stream is 0..14 in order, values (k, -k).
  - cap_last asserts only at idx 14.
  - data holds stable during stalls.
  - cap_req mid-stream is ignored.
- Assert reset during ARMED and mid-stream -> outputs return to reset values; after release, frame_sync causes no swap.

Source files
------------

// File: rtl/dpd_coef_ctrl.sv
// dpd_coef_ctrl: double-buffered DPD coefficient bank with a frame-aligned atomic swap,
// plus a snapshot-and-stream path for the core's basis terms.
module dpd_coef_ctrl #(
    parameter int W = 20,
    parameter int N = 15,
    parameter logic [W-1:0] C0_RESET = 20'h40000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           wr_valid,
    output logic           wr_ready,
    input  logic [3:0]     wr_idx,
    input  logic [W-1:0]   wr_i,
    input  logic [W-1:0]   wr_q,
    output logic           wr_err,
    input  logic           commit,
    input  logic           frame_sync,
    output logic           commit_busy,
    output logic           commit_done,
    output logic [N*W-1:0] coef_i,
    output logic [N*W-1:0] coef_q,
    input  logic [N*W-1:0] yy_i,
    input  logic [N*W-1:0] yy_q,
    input  logic           cap_req,
    output logic           cap_valid,
    input  logic           cap_ready,
    output logic [3:0]     cap_idx,
    output logic [W-1:0]   cap_i,
    output logic [W-1:0]   cap_q,
    output logic           cap_last
);
    typedef enum logic {IDLE, ARMED} state_t;
    typedef enum logic {C_IDLE, C_STREAM} cstate_t;
    localparam logic [3:0] LIM  = 4'(N);
    localparam logic [3:0] LAST = 4'(N - 1);
    state_t        state, state_nx;
    cstate_t       cstate, cstate_nx;
    logic [W-1:0]  sh_i [N];
    logic [W-1:0]  sh_q [N];
    logic [W-1:0]  snap_i [N];
    logic [W-1:0]  snap_q [N];
    logic          wr_fire, swap, cap_start, cap_fire, cap_end;
    assign wr_ready    = (state == IDLE);
    assign commit_busy = (state == ARMED);
    assign cap_valid   = (cstate == C_STREAM);
    assign wr_fire     = wr_valid & wr_ready;
    assign swap        = commit_busy & frame_sync;
    assign cap_start   = !cap_valid & cap_req;
    assign cap_fire    = cap_valid & cap_ready;
    assign cap_end     = cap_fire & (cap_idx == LAST);
    always_comb begin
        state_nx  = (state == IDLE) ? (commit ? ARMED : IDLE) : (frame_sync ? IDLE : ARMED);
        cstate_nx = (cstate == C_IDLE) ? (cap_req ? C_STREAM : C_IDLE) : (cap_end ? C_IDLE : C_STREAM);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cstate <= C_IDLE;
        end else begin
            state  <= state_nx;
            cstate <= cstate_nx;
        end
    end
    // Writes are blocked while ARMED, so a swap never races a shadow update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                sh_i[k]          <= (k == 0) ? C0_RESET : '0;
                sh_q[k]          <= '0;
                coef_i[k*W +: W] <= (k == 0) ? C0_RESET : '0;
                coef_q[k*W +: W] <= '0;
            end
            wr_err      <= 1'b0;
            commit_done <= 1'b0;
        end else begin
            wr_err      <= wr_fire & (wr_idx >= LIM);
            commit_done <= swap;
            if (wr_fire && wr_idx < LIM) begin
                sh_i[wr_idx] <= wr_i;
                sh_q[wr_idx] <= wr_q;
            end
            if (swap) begin
                for (int k = 0; k < N; k++) begin
                    coef_i[k*W +: W] <= sh_i[k];
                    coef_q[k*W +: W] <= sh_q[k];
                end
            end
        end
    end
    // Output entry is preloaded from the snapshot so cap_i/cap_q stay registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                snap_i[k] <= '0;
                snap_q[k] <= '0;
            end
            cap_idx  <= '0;
            cap_i    <= '0;
            cap_q    <= '0;
            cap_last <= 1'b0;
        end else if (cap_start) begin
            for (int k = 0; k < N; k++) begin
                snap_i[k] <= yy_i[k*W +: W];
                snap_q[k] <= yy_q[k*W +: W];
            end
            cap_idx  <= '0;
            cap_i    <= yy_i[W-1:0];
            cap_q    <= yy_q[W-1:0];
            cap_last <= (N == 1);
        end else if (cap_end) begin
            cap_last <= 1'b0;
        end else if (cap_fire) begin
            cap_idx  <= cap_idx + 4'd1;
            cap_i    <= snap_i[cap_idx + 4'd1];
            cap_q    <= snap_q[cap_idx + 4'd1];
            cap_last <= (cap_idx + 4'd1 == LAST);
        end
    end
endmodule

// File: tb/tb_dpd_coef_ctrl.sv
// tb_dpd_coef_ctrl: randomized checks of the coefficient double-buffer and basis capture
// against a bank/array model of the controller.
module tb_dpd_coef_ctrl;
    localparam int W = 20;
    localparam int N = 15;
    logic           clk = 0, reset = 1;
    logic           wr_valid = 0, wr_ready, wr_err;
    logic [3:0]     wr_idx = 0;
    logic [W-1:0]   wr_i = 0, wr_q = 0;
    logic           commit = 0, frame_sync = 0, commit_busy, commit_done;
    logic [N*W-1:0] coef_i, coef_q, yy_i = 0, yy_q = 0;
    logic           cap_req = 0, cap_valid, cap_ready = 0, cap_last;
    logic [3:0]     cap_idx;
    logic [W-1:0]   cap_i, cap_q;
    int             n_checks = 0, n_fail = 0;
    logic [W-1:0]   m_act_i [N], m_act_q [N], m_sh_i [N], m_sh_q [N], e_i [N], e_q [N];
    bit             m_armed;

    always #5 clk = ~clk;

    dpd_coef_ctrl dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx),
        .wr_i(wr_i), .wr_q(wr_q), .wr_err(wr_err), .commit(commit), .frame_sync(frame_sync),
        .commit_busy(commit_busy), .commit_done(commit_done), .coef_i(coef_i), .coef_q(coef_q),
        .yy_i(yy_i), .yy_q(yy_q), .cap_req(cap_req), .cap_valid(cap_valid), .cap_ready(cap_ready),
        .cap_idx(cap_idx), .cap_i(cap_i), .cap_q(cap_q), .cap_last(cap_last)
    );

    function automatic logic [N*W-1:0] pack(input logic [W-1:0] a [N]);
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = a[k];
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        for (int k = 0; k < N; k++) begin
            m_act_i[k] = (k == 0) ? 20'h40000 : '0;
            m_act_q[k] = '0;
            m_sh_i[k]  = m_act_i[k];
            m_sh_q[k]  = '0;
        end
        m_armed = 0;
    endtask

    task automatic do_write(input int idx, input logic [W-1:0] di, input logic [W-1:0] dq, input bit with_commit);
        wr_valid = 1; wr_idx = 4'(idx); wr_i = di; wr_q = dq; commit = with_commit;
        tick;
        wr_valid = 0; commit = 0;
        if (idx < N) begin
            m_sh_i[idx] = di;
            m_sh_q[idx] = dq;
        end
        if (with_commit) m_armed = 1;
    endtask

    task automatic do_commit;
        commit = 1;
        tick;
        commit = 0;
        m_armed = 1;
    endtask

    task automatic do_frame;
        frame_sync = 1;
        tick;
        frame_sync = 0;
        if (m_armed) begin
            m_act_i = m_sh_i;
            m_act_q = m_sh_q;
            m_armed = 0;
        end
    endtask

    task automatic test_reset;
        reset = 1;
        tick; tick;
        reset = 0;
        model_reset;
        tick;
        n_checks++; if (coef_i !== pack(m_act_i) || coef_q !== pack(m_act_q)) begin n_fail++; $display("FAIL reset_coef got i=%h q=%h", coef_i, coef_q); end
        n_checks++; if (coef_i[W-1:0] !== 20'h40000) begin n_fail++; $display("FAIL reset_c0 got %h want 40000", coef_i[W-1:0]); end
        n_checks++; if (wr_ready !== 1'b1 || commit_busy !== 1'b0 || commit_done !== 1'b0 || wr_err !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl got rdy=%b busy=%b done=%b err=%b", wr_ready, commit_busy, commit_done, wr_err); end
        n_checks++; if (cap_valid !== 1'b0 || cap_idx !== 4'd0 || cap_last !== 1'b0 || cap_i !== '0 || cap_q !== '0) begin n_fail++; $display("FAIL reset_cap got v=%b idx=%0d last=%b i=%h q=%h", cap_valid, cap_idx, cap_last, cap_i, cap_q); end
    endtask

    task automatic test_commit;
        do_write(3, 20'h00100, 20'h3FF00, 0);
        do_commit;
        n_checks++; if (commit_busy !== 1'b1 || wr_ready !== 1'b0) begin n_fail++; $display("FAIL commit_armed got busy=%b rdy=%b want 1 0", commit_busy, wr_ready); end
        for (int c = 0; c < 10; c++) begin
            tick;
            n_checks++; if (coef_i !== pack(m_act_i) || coef_q !== pack(m_act_q) || wr_ready !== 1'b0 || commit_done !== 1'b0) begin n_fail++; $display("FAIL commit_hold c=%0d rdy=%b done=%b coef_i=%h", c, wr_ready, commit_done, coef_i); end
        end
        do_frame;
        n_checks++; if (coef_i !== pack(m_act_i) || coef_q !== pack(m_act_q)) begin n_fail++; $display("FAIL commit_swap got i=%h q=%h", coef_i, coef_q); end
        n_checks++; if (coef_i[3*W +: W] !== 20'h00100 || coef_q[3*W +: W] !== 20'h3FF00) begin n_fail++; $display("FAIL commit_e3 got (%h,%h) want (00100,3ff00)", coef_i[3*W +: W], coef_q[3*W +: W]); end
        n_checks++; if (commit_done !== 1'b1 || commit_busy !== 1'b0 || wr_ready !== 1'b1) begin n_fail++; $display("FAIL commit_done got done=%b busy=%b rdy=%b want 1 0 1", commit_done, commit_busy, wr_ready); end
        tick;
        n_checks++; if (commit_done !== 1'b0) begin n_fail++; $display("FAIL commit_pulse got done=%b want 0", commit_done); end
    endtask

    task automatic test_random_writes;
        for (int r = 0; r < 6; r++) begin
            int nw = $urandom_range(1, 5);
            for (int w = 0; w < nw; w++)
                do_write($urandom_range(0, N - 1), W'($urandom), W'($urandom), w == nw - 1);
            for (int d = $urandom_range(0, 6); d > 0; d--) begin
                tick;
                n_checks++; if (coef_i !== pack(m_act_i) || coef_q !== pack(m_act_q) || commit_busy !== 1'b1) begin n_fail++; $display("FAIL rand_hold r=%0d busy=%b coef_i=%h want %h", r, commit_busy, coef_i, pack(m_act_i)); end
            end
            do_frame;
            n_checks++; if (coef_i !== pack(m_act_i) || coef_q !== pack(m_act_q) || commit_done !== 1'b1) begin n_fail++; $display("FAIL rand_swap r=%0d done=%b coef_i=%h want %h", r, commit_done, coef_i, pack(m_act_i)); end
        end
    endtask

    task automatic test_bad_idx;
        logic [N*W-1:0] before_i, before_q;
        before_i = pack(m_act_i);
        before_q = pack(m_act_q);
        do_write(15, W'($urandom), W'($urandom), 0);
        n_checks++; if (wr_err !== 1'b1) begin n_fail++; $display("FAIL bad_err got %b want 1", wr_err); end
        tick;
        n_checks++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL bad_err_pulse got %b want 0", wr_err); end
        do_commit;
        tick; tick;
        do_frame;
        n_checks++; if (coef_i !== before_i || coef_q !== before_q || commit_done !== 1'b1) begin n_fail++; $display("FAIL bad_nochange done=%b coef_i=%h want %h", commit_done, coef_i, before_i); end
    endtask

    task automatic test_ignored;
        int dones;
        do_write(5, W'($urandom), W'($urandom), 0);
        do_frame;
        n_checks++; if (coef_i !== pack(m_act_i) || coef_q !== pack(m_act_q) || commit_done !== 1'b0) begin n_fail++; $display("FAIL idle_frame done=%b coef_i=%h want %h", commit_done, coef_i, pack(m_act_i)); end
        do_commit;
        commit = 1;
        tick; tick;
        commit = 0;
        n_checks++; if (commit_busy !== 1'b1) begin n_fail++; $display("FAIL rearm_busy got %b want 1", commit_busy); end
        do_frame;
        dones = int'(commit_done);
        for (int c = 0; c < 6; c++) begin
            frame_sync = c[0];
            tick;
            dones += int'(commit_done);
        end
        frame_sync = 0;
        n_checks++; if (dones != 1 || commit_busy !== 1'b0) begin n_fail++; $display("FAIL one_swap got dones=%0d busy=%b want 1 0", dones, commit_busy); end
        n_checks++; if (coef_i !== pack(m_act_i) || coef_q !== pack(m_act_q)) begin n_fail++; $display("FAIL one_swap_coef got %h want %h", coef_i, pack(m_act_i)); end
    endtask

    task automatic test_capture;
        for (int run = 0; run < 3; run++) begin
            int e = 0, cyc = 0;
            for (int k = 0; k < N; k++) begin
                e_i[k] = (run == 0) ? W'(k) : W'($urandom);
                e_q[k] = (run == 0) ? W'(-k) : W'($urandom);
                yy_i[k*W +: W] = e_i[k];
                yy_q[k*W +: W] = e_q[k];
            end
            cap_req = 1;
            tick;
            cap_req = 0;
            yy_i = {N{W'($urandom)}};
            yy_q = {N{W'($urandom)}};
            while (e < N && cyc < 200) begin
                n_checks++; if (cap_valid !== 1'b1 || cap_idx !== 4'(e) || cap_i !== e_i[e] || cap_q !== e_q[e] || cap_last !== (e == N - 1)) begin n_fail++; $display("FAIL cap run=%0d cyc=%0d got v=%b idx=%0d (%h,%h) last=%b want idx=%0d (%h,%h)", run, cyc, cap_valid, cap_idx, cap_i, cap_q, cap_last, e, e_i[e], e_q[e]); end
                cap_ready = (run == 0) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
                cap_req = (cyc == 4);
                tick;
                cap_req = 0;
                if (cap_ready) e++;
                cyc++;
            end
            cap_ready = 0;
            n_checks++; if (e < N) begin n_fail++; $display("FAIL cap_timeout run=%0d got %0d entries want %0d", run, e, N); end
            n_checks++; if (cap_valid !== 1'b0) begin n_fail++; $display("FAIL cap_end run=%0d got valid=%b want 0", run, cap_valid); end
        end
    endtask

    task automatic test_reset_mid;
        do_write(7, W'($urandom) | 20'h1, W'($urandom), 0);
        do_commit;
        yy_i = {N{W'($urandom)}};
        cap_req = 1;
        tick;
        cap_req = 0;
        tick;
        n_checks++; if (commit_busy !== 1'b1 || cap_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre got busy=%b valid=%b want 1 1", commit_busy, cap_valid); end
        #2;
        reset = 1;
        #1;
        model_reset;
        n_checks++; if (cap_valid !== 1'b0 || commit_busy !== 1'b0 || wr_ready !== 1'b1 || cap_idx !== 4'd0 || cap_last !== 1'b0) begin n_fail++; $display("FAIL async_rst got valid=%b busy=%b rdy=%b idx=%0d last=%b", cap_valid, commit_busy, wr_ready, cap_idx, cap_last); end
        n_checks++; if (coef_i !== pack(m_act_i) || coef_q !== pack(m_act_q)) begin n_fail++; $display("FAIL async_rst_coef got %h want %h", coef_i, pack(m_act_i)); end
        tick;
        reset = 0;
        tick;
        do_frame;
        n_checks++; if (coef_i !== pack(m_act_i) || coef_q !== pack(m_act_q) || commit_done !== 1'b0) begin n_fail++; $display("FAIL post_rst_frame done=%b coef_i=%h want %h", commit_done, coef_i, pack(m_act_i)); end
        do_commit;
        do_frame;
        n_checks++; if (coef_i !== pack(m_act_i) || coef_q !== pack(m_act_q) || commit_done !== 1'b1) begin n_fail++; $display("FAIL post_rst_shadow done=%b coef_i=%h want %h", commit_done, coef_i, pack(m_act_i)); end
    endtask

    initial begin
        test_reset;
        test_commit;
        test_random_writes;
        test_bad_idx;
        test_ignored;
        test_capture;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
